// File: rtl/ntt_opt_pkg.sv
// Shared types for the NTT corner-turn scheduler: per-bank occupancy state.
package ntt_opt_pkg;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/ntt_bank_fsm.sv
// Occupancy tracker for one corner-turn bank: FREE -> FILLING -> FULL -> FREE.
module ntt_bank_fsm
  import ntt_opt_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fill_beat,
  input  logic        i_fill_last,
  input  logic        i_drain_done,
  output bank_state_e o_state
);

  bank_state_e r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= BANK_FREE;
    end else begin
      case (r_state)
        BANK_FREE:    if (i_fill_beat)  r_state <= BANK_FILLING;
        BANK_FILLING: if (i_fill_last)  r_state <= BANK_FULL;
        BANK_FULL:    if (i_drain_done) r_state <= BANK_FREE;
        default:                        r_state <= BANK_FREE;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/ntt_cgram_sched.sv
// Ping-pong scheduler for a two-bank corner-turn buffer: write/read pointers,
// beat counters, frame counters and sticky framing/underflow error flags.
module ntt_cgram_sched
  import ntt_opt_pkg::*;
#(
  parameter int N     = 2**11,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  output logic             buf_valid_o,
  output logic             buf_bank_o,
  input  logic             drain_valid_i,
  output logic             drain_last_o,
  output logic [CNT_W-1:0] frames_in_o,
  output logic [CNT_W-1:0] frames_out_o,
  output logic             busy_o,
  output logic             err_last_o,
  output logic             err_drain_o
);

  localparam int PTR_W = $clog2(N);
  localparam logic [PTR_W-1:0] LAST_BEAT = PTR_W'(N - 1);

  logic             r_wbank;
  logic             r_rbank;
  logic [PTR_W-1:0] r_wcnt;
  logic [PTR_W-1:0] r_dcnt;
  logic [CNT_W-1:0] r_frames_in;
  logic [CNT_W-1:0] r_frames_out;
  logic             r_drain_last;
  logic             r_err_last;
  logic             r_err_drain;

  bank_state_e      w_state [2];
  logic             w_accept;
  logic             w_fill_last;
  logic             w_drain_ok;
  logic             w_drain_done;

  // Ready depends only on registered bank state, so a freed bank is seen one cycle later.
  assign s_ready_o    = (w_state[r_wbank] != BANK_FULL);
  assign w_accept     = s_valid_i && s_ready_o;
  assign w_fill_last  = w_accept && (r_wcnt == LAST_BEAT);
  assign w_drain_ok   = drain_valid_i && (w_state[r_rbank] == BANK_FULL);
  assign w_drain_done = w_drain_ok && (r_dcnt == LAST_BEAT);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ntt_bank_fsm u_bank (
      .i_clk        (clk_i),
      .i_rst        (rst_i),
      .i_fill_beat  (w_accept && (r_wbank == 1'(b))),
      .i_fill_last  (w_fill_last && (r_wbank == 1'(b))),
      .i_drain_done (w_drain_done && (r_rbank == 1'(b))),
      .o_state      (w_state[b])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wbank      <= 1'b0;
      r_wcnt       <= '0;
      r_frames_in  <= '0;
      r_err_last   <= 1'b0;
    end else if (w_accept) begin
      r_wcnt <= w_fill_last ? '0 : r_wcnt + 1'b1;
      if (w_fill_last) begin
        r_wbank     <= ~r_wbank;
        r_frames_in <= r_frames_in + 1'b1;
      end
      // Framing follows the beat count; a disagreeing s_last_i is only flagged.
      if (s_last_i != (r_wcnt == LAST_BEAT))
        r_err_last <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rbank      <= 1'b0;
      r_dcnt       <= '0;
      r_frames_out <= '0;
      r_drain_last <= 1'b0;
      r_err_drain  <= 1'b0;
    end else begin
      r_drain_last <= w_drain_done;
      if (w_drain_ok) begin
        r_dcnt <= w_drain_done ? '0 : r_dcnt + 1'b1;
        if (w_drain_done) begin
          r_rbank      <= ~r_rbank;
          r_frames_out <= r_frames_out + 1'b1;
        end
      end else if (drain_valid_i) begin
        r_err_drain <= 1'b1;
      end
    end
  end

  assign buf_valid_o  = w_accept;
  assign buf_bank_o   = r_wbank;
  assign drain_last_o = r_drain_last;
  assign frames_in_o  = r_frames_in;
  assign frames_out_o = r_frames_out;
  assign busy_o       = (w_state[0] != BANK_FREE) || (w_state[1] != BANK_FREE);
  assign err_last_o   = r_err_last;
  assign err_drain_o  = r_err_drain;

endmodule

// File: tb/tb_ntt_cgram_sched.sv
// Self-checking bench for ntt_cgram_sched with N=4; drain_last pulses are scored against a queue.
module tb_ntt_cgram_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        buf_valid;
  logic        buf_bank;
  logic        drain_valid;
  logic        drain_last;
  logic [15:0] frames_in;
  logic [15:0] frames_out;
  logic        busy;
  logic        err_last;
  logic        err_drain;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  ntt_cgram_sched #(.N(4), .CNT_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_valid_i    (s_valid),
    .s_last_i     (s_last),
    .s_ready_o    (s_ready),
    .buf_valid_o  (buf_valid),
    .buf_bank_o   (buf_bank),
    .drain_valid_i(drain_valid),
    .drain_last_o (drain_last),
    .frames_in_o  (frames_in),
    .frames_out_o (frames_out),
    .busy_o       (busy),
    .err_last_o   (err_last),
    .err_drain_o  (err_drain)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; drain_valid = 1'b0;
    cyc(); cyc();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0d exp=1", s_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d exp=0", busy); end
    checks++; if (buf_valid !== 1'b0) begin failures++; $display("FAIL rst_buf_valid got=%0d exp=0", buf_valid); end
    checks++; if (buf_bank !== 1'b0) begin failures++; $display("FAIL rst_buf_bank got=%0d exp=0", buf_bank); end
    checks++; if (frames_in !== 16'd0 || frames_out !== 16'd0) begin failures++; $display("FAIL rst_frames got=%0d/%0d exp=0/0", frames_in, frames_out); end
    checks++; if (err_last !== 1'b0 || err_drain !== 1'b0 || drain_last !== 1'b0) begin failures++; $display("FAIL rst_flags got=%0d%0d%0d exp=000", err_last, err_drain, drain_last); end
    rst = 1'b0;
    s_valid = 1'b1; #1;
    checks++; if (buf_valid !== 1'b1) begin failures++; $display("FAIL buf_valid_strobe got=%0d exp=1", buf_valid); end
    s_valid = 1'b0; #1;
  endtask

  task automatic test_fill_one();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_last = (i == 3);
      #1;
      checks++; if (buf_valid !== 1'b1) begin failures++; $display("FAIL fill_accept beat=%0d got=%0d exp=1", i, buf_valid); end
      cyc();
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (frames_in !== 16'd1) begin failures++; $display("FAIL fill_frames_in got=%0d exp=1", frames_in); end
    checks++; if (buf_bank !== 1'b1) begin failures++; $display("FAIL fill_bank got=%0d exp=1", buf_bank); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fill_busy got=%0d exp=1", busy); end
    checks++; if (err_last !== 1'b0) begin failures++; $display("FAIL fill_err_last got=%0d exp=0", err_last); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_last = (i == 3);
      cyc();
    end
    s_last = 1'b0;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%0d exp=0", s_ready); end
    checks++; if (frames_in !== 16'd2) begin failures++; $display("FAIL bp_frames_in got=%0d exp=2", frames_in); end
    checks++; if (buf_valid !== 1'b0) begin failures++; $display("FAIL bp_ninth_accept got=%0d exp=0", buf_valid); end
    cyc();
    s_valid = 1'b0;
    checks++; if (frames_in !== 16'd2 || s_ready !== 1'b0) begin failures++; $display("FAIL bp_hold got=%0d/%0d exp=2/0", frames_in, s_ready); end
  endtask

  task automatic test_drain();
    int pulses = 0;
    for (int f = 1; f <= 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        drain_valid = 1'b1;
        if (i == 3) exp_q.push_back(f);
        cyc();
        if (drain_last) begin
          pulses++;
          checks++;
          if (exp_q.size() == 0) begin failures++; $display("FAIL drain_unexpected_pulse got=%0d exp=none", frames_out); end
          else begin
            int e = exp_q.pop_front();
            if (frames_out !== 16'(e)) begin failures++; $display("FAIL drain_frames_out got=%0d exp=%0d", frames_out, e); end
          end
        end
      end
      drain_valid = 1'b0;
      if (f == 1) begin
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL drain_ready_after got=%0d exp=1", s_ready); end
      end
      cyc();
      checks++; if (drain_last !== 1'b0) begin failures++; $display("FAIL drain_pulse_width got=%0d exp=0", drain_last); end
    end
    checks++; if (pulses != 2) begin failures++; $display("FAIL drain_pulse_count got=%0d exp=2", pulses); end
    checks++; if (frames_out !== 16'd2 || busy !== 1'b0) begin failures++; $display("FAIL drain_idle got=%0d/%0d exp=2/0", frames_out, busy); end
  endtask

  task automatic test_back_to_back();
    int bubbles = 0;
    int pulses = 0;
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int c = 0; c < 44; c++) begin
      s_valid = (c < 40); s_last = ((c % 4) == 3); drain_valid = (c >= 4);
      #1;
      if (c < 40 && s_ready !== 1'b1) bubbles++;
      if (c >= 4 && ((c - 4) % 4) == 3) exp_q.push_back((c - 4) / 4 + 1);
      cyc();
      if (drain_last) begin
        pulses++;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_unexpected_pulse got=%0d exp=none", frames_out); end
        else begin
          int e = exp_q.pop_front();
          if (frames_out !== 16'(e)) begin failures++; $display("FAIL b2b_frames_out got=%0d exp=%0d", frames_out, e); end
        end
      end
    end
    s_valid = 1'b0; s_last = 1'b0; drain_valid = 1'b0;
    checks++; if (bubbles != 0) begin failures++; $display("FAIL b2b_bubbles got=%0d exp=0", bubbles); end
    checks++; if (pulses != 10 || exp_q.size() != 0) begin failures++; $display("FAIL b2b_pulses got=%0d exp=10", pulses); end
    checks++; if (frames_in !== 16'd10 || frames_out !== 16'd10) begin failures++; $display("FAIL b2b_frames got=%0d/%0d exp=10/10", frames_in, frames_out); end
    checks++; if (err_last !== 1'b0 || err_drain !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_flags got=%0d%0d%0d exp=000", err_last, err_drain, busy); end
  endtask

  task automatic test_errors();
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_last = (i == 2);
      cyc();
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (err_last !== 1'b1) begin failures++; $display("FAIL err_last_set got=%0d exp=1", err_last); end
    checks++; if (err_drain !== 1'b0) begin failures++; $display("FAIL err_drain_early got=%0d exp=0", err_drain); end
    drain_valid = 1'b1; cyc(); drain_valid = 1'b0;
    checks++; if (err_drain !== 1'b1) begin failures++; $display("FAIL err_drain_set got=%0d exp=1", err_drain); end
    for (int i = 0; i < 3; i++) cyc();
    checks++; if (err_last !== 1'b1 || err_drain !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0d%0d exp=11", err_last, err_drain); end
    checks++; if (frames_out !== 16'd0 || drain_last !== 1'b0) begin failures++; $display("FAIL err_no_count got=%0d exp=0", frames_out); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_last = 1'b0;
      cyc();
    end
    s_valid = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    checks++; if (busy !== 1'b0 || s_ready !== 1'b1 || buf_bank !== 1'b0) begin failures++; $display("FAIL mid_rst_state got=%0d%0d%0d exp=010", busy, s_ready, buf_bank); end
    checks++; if (err_last !== 1'b0 || err_drain !== 1'b0) begin failures++; $display("FAIL mid_rst_errs got=%0d%0d exp=00", err_last, err_drain); end
    checks++; if (frames_in !== 16'd0 || frames_out !== 16'd0) begin failures++; $display("FAIL mid_rst_frames got=%0d/%0d exp=0/0", frames_in, frames_out); end
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_last = (i == 3);
      cyc();
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (frames_in !== 16'd1 || buf_bank !== 1'b1) begin failures++; $display("FAIL mid_fresh_frame got=%0d/%0d exp=1/1", frames_in, buf_bank); end
    checks++; if (err_last !== 1'b0) begin failures++; $display("FAIL mid_fresh_err got=%0d exp=0", err_last); end
  endtask

  initial begin
    test_reset();
    test_fill_one();
    test_backpressure();
    test_drain();
    test_back_to_back();
    test_errors();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
